// File: rtl/ep2_cmd_sequencer_if.sv
// EP2 command sequencer bus bundle: OUT buffer read port, I2C wishbone
// master and EP IN response port. master = sequencer side.
interface ep2_cmd_sequencer_if;
  logic       buf_out_hasdata;
  logic [7:0] buf_out_q;
  logic [9:0] buf_out_len;
  logic [8:0] buf_out_addr;
  logic       buf_out_arm;
  logic       buf_out_arm_ack;

  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;

  logic [8:0] usb_in_addr;
  logic [7:0] usb_in_data;
  logic       usb_in_wren;
  logic       usb_in_commit;
  logic [9:0] usb_in_commit_len;
  logic       usb_in_ready;
  logic       usb_in_commit_ack;

  modport master (
    input  buf_out_hasdata, buf_out_q, buf_out_len,
    output buf_out_addr, buf_out_arm,
    input  buf_out_arm_ack,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i,
    output usb_in_addr, usb_in_data, usb_in_wren,
    output usb_in_commit, usb_in_commit_len,
    input  usb_in_ready, usb_in_commit_ack
  );

  modport slave (
    output buf_out_hasdata, buf_out_q, buf_out_len,
    input  buf_out_addr, buf_out_arm,
    output buf_out_arm_ack,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
    output wb_dat_i, wb_ack_i,
    input  usb_in_addr, usb_in_data, usb_in_wren,
    input  usb_in_commit, usb_in_commit_len,
    output usb_in_ready, usb_in_commit_ack
  );
endinterface

// File: rtl/ep2_cmd_sequencer.sv
// EP2 OUT {addr,data} command interpreter driving I2C wishbone and EP IN.
// Optional: define CMD_STATUS_EN to enable the addr 10 status read.
module ep2_cmd_sequencer #(
  parameter int RD_LAT     = 4,
  parameter int WB_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  ep2_cmd_sequencer_if.master bus,
  output logic [7:0]          reset_ctrl,
  output logic [1:0]          insel,
  output logic [10:0]         isoc_commit_len
);
  localparam int CMAX = (WB_TIMEOUT > RD_LAT) ? WB_TIMEOUT : RD_LAT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WB_LAST = CW'(WB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH_A, FETCH_D, EXEC,
    WB_WAIT, RELEASE, COMMIT, COMMIT_WAIT
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0] pair_q, pair_d;
  logic [9:0] len_q, len_d;
  logic [7:0] cmd_a_q, cmd_a_d;
  logic [7:0] cmd_d_q, cmd_d_d;
  logic [8:0] buf_out_addr_q, buf_out_addr_d;
  logic       arm_q, arm_d;
  logic [2:0] wb_adr_q, wb_adr_d;
  logic [7:0] wb_dat_q, wb_dat_d;
  logic       wb_we_q, wb_we_d;
  logic       wb_stb_q, wb_stb_d;
  logic [8:0] in_addr_q, in_addr_d;
  logic [7:0] in_data_q, in_data_d;
  logic       in_wren_q, in_wren_d;
  logic       commit_q, commit_d;
  logic [9:0] commit_len_q, commit_len_d;
  logic [9:0] resp_cnt_q, resp_cnt_d;
  logic [7:0] reset_ctrl_q, reset_ctrl_d;
  logic [1:0] insel_q, insel_d;
  logic [10:0] iso_q, iso_d;
  logic       unk_q, unk_d;
  logic       tmo_q, tmo_d;
  logic       ack_s1_q, ack_s2_q, ack_s3_q;

  logic       advance, resp_we, unk_set, tmo_set, sts_clr;
  logic [7:0] resp_byte;
  logic [8:0] pair_nx;

  assign pair_nx = pair_q + 9'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pair_d         = pair_q;
    len_d          = len_q;
    cmd_a_d        = cmd_a_q;
    cmd_d_d        = cmd_d_q;
    buf_out_addr_d = buf_out_addr_q;
    arm_d          = arm_q;
    wb_adr_d       = wb_adr_q;
    wb_dat_d       = wb_dat_q;
    wb_we_d        = wb_we_q;
    wb_stb_d       = wb_stb_q;
    in_addr_d      = in_addr_q;
    in_data_d      = in_data_q;
    in_wren_d      = 1'b0;
    commit_d       = commit_q;
    commit_len_d   = commit_len_q;
    resp_cnt_d     = resp_cnt_q;
    reset_ctrl_d   = reset_ctrl_q;
    insel_d        = insel_q;
    iso_d          = iso_q;
    advance        = 1'b0;
    resp_we        = 1'b0;
    resp_byte      = 8'h00;
    unk_set        = 1'b0;
    tmo_set        = 1'b0;
    sts_clr        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.buf_out_hasdata) begin
          pair_d         = 9'd0;
          len_d          = bus.buf_out_len;
          resp_cnt_d     = 10'd0;
          buf_out_addr_d = 9'd0;
          cnt_d          = '0;
          if (bus.buf_out_len < 10'd2) begin
            arm_d   = 1'b1;
            state_d = RELEASE;
          end else begin
            state_d = FETCH_A;
          end
        end
      end
      FETCH_A: begin
        if (cnt_q == RD_LAST) begin
          cmd_a_d        = bus.buf_out_q;
          buf_out_addr_d = {pair_q[7:0], 1'b1};
          cnt_d          = '0;
          state_d        = FETCH_D;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FETCH_D: begin
        if (cnt_q == RD_LAST) begin
          cmd_d_d = bus.buf_out_q;
          cnt_d   = '0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        unique case (1'b1)
          (cmd_a_q <= 8'd4): begin
            wb_stb_d = 1'b1;
            wb_we_d  = 1'b1;
            wb_adr_d = cmd_a_q[2:0];
            wb_dat_d = cmd_d_q;
            cnt_d    = '0;
            state_d  = WB_WAIT;
          end
          (cmd_a_q == 8'd5): begin
            wb_stb_d = 1'b1;
            wb_we_d  = 1'b0;
            wb_adr_d = cmd_d_q[2:0];
            cnt_d    = '0;
            state_d  = WB_WAIT;
          end
          (cmd_a_q == 8'd6): begin
            reset_ctrl_d = cmd_d_q;
            advance      = 1'b1;
          end
          (cmd_a_q == 8'd7): begin
            insel_d = cmd_d_q[1:0];
            advance = 1'b1;
          end
          (cmd_a_q == 8'd8): begin
            iso_d[10:8] = cmd_d_q[2:0];
            advance     = 1'b1;
          end
          (cmd_a_q == 8'd9): begin
            iso_d[7:0] = cmd_d_q;
            advance    = 1'b1;
          end
`ifdef CMD_STATUS_EN
          (cmd_a_q == 8'd10): begin
            resp_we   = 1'b1;
            resp_byte = {tmo_q, unk_q, 6'd0};
            sts_clr   = 1'b1;
            advance   = 1'b1;
          end
`endif
          default: begin
            unk_set = 1'b1;
            advance = 1'b1;
          end
        endcase
      end
      WB_WAIT: begin
        if (bus.wb_ack_i) begin
          wb_stb_d  = 1'b0;
          wb_we_d   = 1'b0;
          resp_we   = ~wb_we_q;
          resp_byte = bus.wb_dat_i;
          advance   = 1'b1;
        end else if (cnt_q == WB_LAST) begin
          wb_stb_d  = 1'b0;
          wb_we_d   = 1'b0;
          tmo_set   = 1'b1;
          resp_we   = ~wb_we_q;
          resp_byte = 8'hEE;
          advance   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (ack_s2_q && !ack_s3_q) begin
          arm_d   = 1'b0;
          state_d = (resp_cnt_q == 10'd0) ? IDLE : COMMIT;
        end
      end
      COMMIT: begin
        if (bus.usb_in_ready) begin
          commit_d     = 1'b1;
          commit_len_d = resp_cnt_q;
          state_d      = COMMIT_WAIT;
        end
      end
      COMMIT_WAIT: begin
        if (bus.usb_in_commit_ack) begin
          commit_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (resp_we) begin
      in_wren_d  = 1'b1;
      in_addr_d  = resp_cnt_q[8:0];
      in_data_d  = resp_byte;
      resp_cnt_d = resp_cnt_q + 10'd1;
    end

    // Next pair exists only if both of its bytes lie inside the packet.
    if (advance) begin
      if ({pair_nx, 1'b1} < len_q) begin
        pair_d         = pair_nx;
        buf_out_addr_d = {pair_nx[7:0], 1'b0};
        cnt_d          = '0;
        state_d        = FETCH_A;
      end else begin
        arm_d   = 1'b1;
        state_d = RELEASE;
      end
    end

    unk_d = (unk_q & ~sts_clr) | unk_set;
    tmo_d = (tmo_q & ~sts_clr) | tmo_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pair_q         <= 9'd0;
      len_q          <= 10'd0;
      cmd_a_q        <= 8'd0;
      cmd_d_q        <= 8'd0;
      buf_out_addr_q <= 9'd0;
      arm_q          <= 1'b0;
      wb_adr_q       <= 3'd0;
      wb_dat_q       <= 8'd0;
      wb_we_q        <= 1'b0;
      wb_stb_q       <= 1'b0;
      in_addr_q      <= 9'd0;
      in_data_q      <= 8'd0;
      in_wren_q      <= 1'b0;
      commit_q       <= 1'b0;
      commit_len_q   <= 10'd0;
      resp_cnt_q     <= 10'd0;
      reset_ctrl_q   <= 8'hF3;
      insel_q        <= 2'd0;
      iso_q          <= 11'd512;
      unk_q          <= 1'b0;
      tmo_q          <= 1'b0;
      ack_s1_q       <= 1'b0;
      ack_s2_q       <= 1'b0;
      ack_s3_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pair_q         <= pair_d;
      len_q          <= len_d;
      cmd_a_q        <= cmd_a_d;
      cmd_d_q        <= cmd_d_d;
      buf_out_addr_q <= buf_out_addr_d;
      arm_q          <= arm_d;
      wb_adr_q       <= wb_adr_d;
      wb_dat_q       <= wb_dat_d;
      wb_we_q        <= wb_we_d;
      wb_stb_q       <= wb_stb_d;
      in_addr_q      <= in_addr_d;
      in_data_q      <= in_data_d;
      in_wren_q      <= in_wren_d;
      commit_q       <= commit_d;
      commit_len_q   <= commit_len_d;
      resp_cnt_q     <= resp_cnt_d;
      reset_ctrl_q   <= reset_ctrl_d;
      insel_q        <= insel_d;
      iso_q          <= iso_d;
      unk_q          <= unk_d;
      tmo_q          <= tmo_d;
      ack_s1_q       <= bus.buf_out_arm_ack;
      ack_s2_q       <= ack_s1_q;
      ack_s3_q       <= ack_s2_q;
    end
  end

  assign bus.buf_out_addr      = buf_out_addr_q;
  assign bus.buf_out_arm       = arm_q;
  assign bus.wb_adr_o          = wb_adr_q;
  assign bus.wb_dat_o          = wb_dat_q;
  assign bus.wb_we_o           = wb_we_q;
  assign bus.wb_stb_o          = wb_stb_q;
  assign bus.usb_in_addr       = in_addr_q;
  assign bus.usb_in_data       = in_data_q;
  assign bus.usb_in_wren       = in_wren_q;
  assign bus.usb_in_commit     = commit_q;
  assign bus.usb_in_commit_len = commit_len_q;
  assign reset_ctrl            = reset_ctrl_q;
  assign insel                 = insel_q;
  assign isoc_commit_len       = iso_q;
endmodule

// File: doc/ep2_cmd_sequencer.md
EP2_CMD_SEQUENCER -- requirements
Module: ep2_cmd_sequencer

Interface
REQ-001 SHALL have parameter RD_LAT, default 4: cycles from a buf_out_addr change to valid buf_out_q.
REQ-002 SHALL have parameter WB_TIMEOUT, default 1024: maximum cycles to wait for wb_ack_i.
REQ-003 SHALL have clk  in  1  single clock for all logic.
REQ-004 SHALL have reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have buf_out_hasdata  in  1 / buf_out_q  in  8 / buf_out_len  in  10  EP2 OUT packet status, data and byte count.
REQ-006 SHALL have buf_out_addr  out  9 / buf_out_arm  out  1 / buf_out_arm_ack  in  1  EP2 OUT read address and release handshake.
REQ-007 SHALL have wb_adr_o  out  3 / wb_dat_o  out  8 / wb_we_o  out  1 / wb_stb_o  out  1 / wb_dat_i  in  8 / wb_ack_i  in  1  I2C core wishbone master.
REQ-008 SHALL have usb_in_addr  out  9 / usb_in_data  out  8 / usb_in_wren  out  1 / usb_in_commit  out  1 / usb_in_commit_len  out  10 / usb_in_ready  in  1 / usb_in_commit_ack  in  1  EP IN response port.
REQ-009 SHALL have reset_ctrl  out  8 / insel  out  2 / isoc_commit_len  out  11  configuration registers.

Function
REQ-010 SHALL treat an OUT packet as pairs {addr, data} at buffer offsets 2k and 2k+1, k = 0 .. floor(buf_out_len/2)-1; an odd trailing byte is ignored.
REQ-011 SHALL sample buf_out_q exactly RD_LAT cycles after setting buf_out_addr.
REQ-012 SHALL use states IDLE -> FETCH_A -> FETCH_D -> EXEC -> (WB_WAIT) -> next pair or RELEASE -> (COMMIT -> COMMIT_WAIT) -> IDLE.
REQ-013 SHALL leave IDLE only when buf_out_hasdata=1; buf_out_len<2 goes directly to RELEASE.
REQ-014 SHALL execute addr 0-4 as a wishbone write: wb_adr_o=addr[2:0], wb_dat_o=data, wb_we_o=1, wb_stb_o=1 until ack.
REQ-015 SHALL execute addr 5 as a wishbone read of wb_adr_o=data[2:0], with we=0; the wb_dat_i captured on ack is written to the IN buffer at the next response index.
REQ-016 SHALL execute addr 6 as reset_ctrl<=data; addr 7 as insel<=data[1:0]; addr 8 as isoc_commit_len[10:8]<=data[2:0]; addr 9 as isoc_commit_len[7:0]<=data; each takes one EXEC cycle.
REQ-017 SHALL ignore all other addresses and set unknown_sticky.
REQ-018 SHALL drop wb_stb_o/wb_we_o on the cycle after wb_ack_i; wb_stb_o SHALL never be asserted in two consecutive transfers without one low cycle between them.
REQ-019 SHALL abort a wishbone transfer after WB_TIMEOUT cycles without ack: drop stb, set timeout_sticky, and for a read return byte 8'hEE.
REQ-020 SHALL write each response byte with a one-cycle usb_in_wren pulse at usb_in_addr = index (0-based, 9-bit counter); the maximum is 256 bytes per packet, so no wrap occurs.
REQ-021 SHALL in RELEASE hold buf_out_arm=1 until a rising edge of buf_out_arm_ack (2-flop synchronised) is detected, then drive it to 0.
REQ-022 SHALL return to IDLE after RELEASE if the response count is 0.
REQ-023 SHALL otherwise wait for usb_in_ready=1, then assert usb_in_commit with usb_in_commit_len = count.
REQ-024 SHALL hold usb_in_commit until usb_in_commit_ack=1, drop it on the next cycle, and return to IDLE.
REQ-025 SHALL ignore buf_out_hasdata outside IDLE; packets are never processed concurrently.

Reset
REQ-026 SHALL, on reset_n=0 at a clk edge, force state IDLE and drive buf_out_addr=0, buf_out_arm=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, usb_in_wren=0, usb_in_commit=0, usb_in_addr=0, usb_in_data=0, usb_in_commit_len=0, reset_ctrl=8'hF3, insel=0, isoc_commit_len=11'd512, and clear the stickies and counters.
REQ-027 SHALL treat reset mid-packet or mid-wishbone as an abort; the pending OUT buffer is not released and is reprocessed after reset.

Configuration
REQ-028 SHALL, with CMD_STATUS_EN defined, execute addr 10 as a status read returning {timeout_sticky, unknown_sticky, 6'd0} as a response byte, clearing both stickies in the same cycle; a set in that same cycle wins.
REQ-029 SHALL, without CMD_STATUS_EN, treat addr 10 as unknown (REQ-017) and omit the status logic.

Verification
REQ-030 SHALL cover: packet {06,A5} -> reset_ctrl=8'hA5; one arm/ack cycle; no usb_in_commit.
REQ-031 SHALL cover: packet {08,02,09,00,07,01} -> isoc_commit_len=11'd512, insel=2'd1; all applied before buf_out_arm rises.
REQ-032 SHALL cover: packet {03,80,05,04} with the bench acking after 3 cycles returning 8'h41 -> wishbone write adr 3 dat 80, then read adr 4; IN byte 0 = 8'h41; commit_len=1, held until ack.
REQ-033 SHALL cover: packet {05,03} with no wb_ack_i -> stb drops after exactly 1024 cycles; IN byte 8'hEE; with CMD_STATUS_EN, a following {0A,00} returns 8'h80 and then 8'h00.
REQ-034 SHALL cover: buf_out_len=3 {06,11,07} -> only reset_ctrl=8'h11; trailing byte ignored; buf_out_len=0 -> immediate release.
REQ-035 SHALL cover: reset_n low during WB_WAIT -> wb_stb_o=0 next cycle, all outputs at reset values, packet reprocessed after reset_n returns high.
